native_in_port: RTL and testbench

Write-side video ingress port of the VDMA. It accepts native video timing (vsync/hsync/de plus pixel data) from a capture source and drives the frame-buffer write FIFO with `wr_en`/`wr_data`. It also generates the frame, line and end-of-frame alignment pulses the write DMA engine uses to place bursts. It checks the received geometry against `hactive`/`vactive` and handles FIFO back-pressure by dropping whole frames.

---
 rtl/native_port_pkg.sv | 23 ++
 rtl/native_in_port_if.sv | 26 ++
 rtl/native_in_edge.sv | 21 ++
 rtl/native_in_port.sv | 163 ++++++++++++++++
 tb/tb_native_in_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/native_port_pkg.sv
// Shared types and constants for the native video ports.
package native_port_pkg;

  localparam int unsigned CNT_W = 16;

  localparam string MODE_ONCE = "ONCE";
  localparam string MODE_LINE = "LINE";

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/native_in_port_if.sv
// Capture-side video timing plus the frame-buffer write FIFO strobe/data.
interface native_in_port_if #(
  parameter int unsigned DSIZE = 24
);

  logic             in_vsync;
  logic             in_hsync;
  logic             in_de;
  logic [DSIZE-1:0] in_data;
  logic             wr_full;
  logic             wr_en;
  logic [DSIZE-1:0] wr_data;

  // Video source and FIFO side.
  modport master (
    output in_vsync, in_hsync, in_de, in_data, wr_full,
    input  wr_en, wr_data
  );

  // Ingress port side.
  modport slave (
    input  in_vsync, in_hsync, in_de, in_data, wr_full,
    output wr_en, wr_data
  );

endinterface

// File: rtl/native_in_edge.sv
// Registered edge detector: one flop of history, combinational rise/fall.
module native_in_edge (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic d_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = ~d_q & d;
  assign fall_c = d_q & ~d;

endmodule

// File: rtl/native_in_port.sv
// Write-side video ingress: native timing in, FIFO writes and alignment
// pulses out, with geometry checks and whole-frame drop on back-pressure.
// Optional statistics counters are built when NATIVE_IN_STATS_EN is defined.
module native_in_port
  import native_port_pkg::*;
#(
  parameter int unsigned DSIZE = 24,
  parameter string       MODE  = MODE_ONCE
) (
  input  logic              clock,
  input  logic              rst_n,
  input  cnt_t              vactive,
  input  cnt_t              hactive,
  native_in_port_if.slave   bus,
  output logic              falign,
  output logic              lalign,
  output logic              ealign,
  output logic              line_err,
  output logic              frame_err,
  output logic              overflow,
  output cnt_t              frame_cnt,
  output cnt_t              err_cnt
);

  localparam bit LINE_MODE = (MODE == MODE_LINE);

  state_t           state, state_nxt;
  cnt_t             pcnt, pcnt_nxt;
  cnt_t             lcnt, lcnt_nxt, lcnt_inc;
  logic             vs_fall, de_fall;
  logic             px_ok, px_drop;
  logic             wr_en_nxt, falign_nxt, lalign_nxt, ealign_nxt;
  logic             line_err_nxt, frame_err_nxt, overflow_nxt;
  logic [DSIZE-1:0] wr_data_q;
  logic             unused_vs_rise, unused_de_rise, unused_hsync;

  assign unused_hsync = bus.in_hsync;

  native_in_edge u_vs_edge (
    .clock  (clock),
    .rst_n  (rst_n),
    .d      (bus.in_vsync),
    .rise_c (unused_vs_rise),
    .fall_c (vs_fall)
  );

  native_in_edge u_de_edge (
    .clock  (clock),
    .rst_n  (rst_n),
    .d      (bus.in_de),
    .rise_c (unused_de_rise),
    .fall_c (de_fall)
  );

  // Pixel accept/drop and line/pixel counter next values; the line closes
  // before a coincident frame start clears the line count.
  always_comb begin
    px_ok    = (state == ST_ACTIVE) && bus.in_de && !bus.wr_full;
    px_drop  = (state == ST_ACTIVE) && bus.in_de && bus.wr_full;
    lcnt_inc = lcnt;
    if (de_fall && ((state == ST_ACTIVE) || (state == ST_DROP))) begin
      if (vactive == '0)       lcnt_inc = sat_inc(lcnt);
      else if (lcnt < vactive) lcnt_inc = lcnt + cnt_t'(1);
    end
    lcnt_nxt = vs_fall ? '0 : lcnt_inc;
    pcnt_nxt = (vs_fall || de_fall) ? '0 : pcnt;
    if (bus.in_de) pcnt_nxt = sat_inc(pcnt_nxt);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a frame start always re-enters ACTIVE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (vs_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (vs_fall)      state_nxt = ST_ACTIVE;
        else if (px_drop) state_nxt = ST_DROP;
        else if (de_fall && (vactive != '0) && (lcnt_inc == vactive))
          state_nxt = ST_BLANK;
      end
      ST_BLANK:  if (vs_fall) state_nxt = ST_ACTIVE;
      ST_DROP:   if (vs_fall) state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered strobes and flags.
  always_comb begin
    wr_en_nxt     = px_ok;
    falign_nxt    = vs_fall;
    lalign_nxt    = LINE_MODE && de_fall && (state == ST_ACTIVE);
    ealign_nxt    = de_fall && (state == ST_ACTIVE) && (vactive != '0) &&
                    (lcnt_inc == vactive);
    line_err_nxt  = de_fall && (state != ST_IDLE) && (pcnt != hactive);
    frame_err_nxt = vs_fall && (state != ST_IDLE) && (lcnt_inc != vactive);
    overflow_nxt  = overflow;
    if (vs_fall) overflow_nxt = 1'b0;
    if (px_drop) overflow_nxt = 1'b1;
  end

  // Per-line pixel count and per-frame line count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      lcnt <= '0;
    end else begin
      pcnt <= pcnt_nxt;
      lcnt <= lcnt_nxt;
    end
  end

  // Output registers; write data only updates on an accepted pixel.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en <= 1'b0;
      wr_data_q <= '0;
      falign    <= 1'b0;
      lalign    <= 1'b0;
      ealign    <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bus.wr_en <= wr_en_nxt;
      if (px_ok) wr_data_q <= bus.in_data;
      falign    <= falign_nxt;
      lalign    <= lalign_nxt;
      ealign    <= ealign_nxt;
      line_err  <= line_err_nxt;
      frame_err <= frame_err_nxt;
      overflow  <= overflow_nxt;
    end
  end

  assign bus.wr_data = wr_data_q;

`ifdef NATIVE_IN_STATS_EN
  logic drop_entry;
  assign drop_entry = (state == ST_ACTIVE) && (state_nxt == ST_DROP);

  // Frame count wraps; error count saturates.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (falign_nxt) frame_cnt <= frame_cnt + cnt_t'(1);
      if (line_err_nxt || frame_err_nxt || drop_entry)
        err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_native_in_port.sv
module tb_native_in_port;

  logic        clock;
  logic        rst_n;
  logic [15:0] vact_s, hact_s;
  logic        falign, lalign, ealign, line_err, frame_err, overflow;
  logic [15:0] frame_cnt, err_cnt;

  native_in_port_if #(.DSIZE(24)) bus ();

  native_in_port #(.DSIZE(24), .MODE("LINE")) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .vactive   (vact_s),
    .hactive   (hact_s),
    .bus       (bus),
    .falign    (falign),
    .lalign    (lalign),
    .ealign    (ealign),
    .line_err  (line_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Running totals gathered away from the active edge.
  int          tot_wr = 0, tot_fal = 0, tot_lal = 0, tot_eal = 0;
  int          tot_lerr = 0, tot_ferr = 0;
  logic [23:0] xor_data = '0;

  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        tot_wr   <= tot_wr + 1;
        xor_data <= xor_data ^ bus.wr_data;
      end
      if (falign)    tot_fal  <= tot_fal + 1;
      if (lalign)    tot_lal  <= tot_lal + 1;
      if (ealign)    tot_eal  <= tot_eal + 1;
      if (line_err)  tot_lerr <= tot_lerr + 1;
      if (frame_err) tot_ferr <= tot_ferr + 1;
    end
  end

  // Bench-side model state: pixel sequence, index within frame, expected XOR.
  int          pseq = 0;
  int          g = 0;
  logic [23:0] exp_xor = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic de, input logic full, input logic [23:0] d);
    bus.in_vsync = vs;
    bus.in_hsync = ~de;
    bus.in_de    = de;
    bus.wr_full  = full;
    bus.in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    idle(3);
  endtask

  // One line of pixels; a pixel is expected in the FIFO unless the frame
  // has overflowed or the line lies past vactive.
  task automatic line(input int len, input int lidx, input int vact,
                      input int full_at, input logic vs_last);
    logic [23:0] d;
    logic        full;
    for (int p = 0; p < len; p++) begin
      g++;
      pseq++;
      d    = 24'(pseq) ^ 24'hA50000;
      full = (full_at != 0) && (g == full_at);
      if (((full_at == 0) || (g < full_at)) && ((vact == 0) || (lidx < vact)))
        exp_xor = exp_xor ^ d;
      cyc(vs_last && (p == len - 1), 1'b1, full, d);
    end
    if (!vs_last) idle(2);
  endtask

  typedef struct {
    int hact; int vact; int nlines; int len; int odd_line; int odd_len; int full_at;
    int e_wr; int e_lal; int e_eal; int e_lerr; int e_ferr; int e_ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int s_wr, s_fal, s_lal, s_eal, s_lerr, s_ferr;

  task automatic snap();
    s_wr = tot_wr; s_fal = tot_fal; s_lal = tot_lal;
    s_eal = tot_eal; s_lerr = tot_lerr; s_ferr = tot_ferr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            hact vact nl len odd olen full   wr lal eal lerr ferr ovf
    vecs[0] = '{4, 3, 3, 4, -1, 0, 0,  12, 3, 1, 0, 0, 0};
    vecs[1] = '{4, 3, 3, 4, -1, 0, 6,   5, 1, 0, 0, 0, 1};
    vecs[2] = '{4, 3, 3, 4, -1, 0, 0,  12, 3, 1, 0, 0, 0};
    vecs[3] = '{4, 3, 3, 4,  1, 5, 0,  13, 3, 1, 1, 0, 0};
    vecs[4] = '{4, 3, 2, 4, -1, 0, 0,   8, 2, 0, 0, 1, 0};
    vecs[5] = '{0, 3, 3, 2, -1, 0, 0,   6, 3, 1, 3, 0, 0};
    vecs[6] = '{4, 0, 2, 4, -1, 0, 0,   8, 2, 0, 0, 1, 0};
    vecs[7] = '{4, 0, 0, 4, -1, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[8] = '{4, 3, 4, 4, -1, 0, 0,  12, 3, 1, 0, 0, 0};
    vecs[9] = '{4, 3, 4, 4,  3, 3, 0,  12, 3, 1, 1, 0, 0};

    rst_n  = 1'b0;
    hact_s = 16'd4;
    vact_s = 16'd3;
    bus.in_vsync = 1'b0; bus.in_hsync = 1'b1; bus.in_de = 1'b0;
    bus.in_data = '0;    bus.wr_full = 1'b0;

    // Frame already running while in reset.
    for (int p = 0; p < 3; p++) cyc(1'b0, 1'b1, 1'b0, 24'(p + 1));
    check("reset wr_en",     int'(bus.wr_en),   0);
    check("reset wr_data",   int'(bus.wr_data), 0);
    check("reset falign",    int'(falign),      0);
    check("reset lalign",    int'(lalign),      0);
    check("reset ealign",    int'(ealign),      0);
    check("reset line_err",  int'(line_err),    0);
    check("reset frame_err", int'(frame_err),   0);
    check("reset overflow",  int'(overflow),    0);
    check("reset frame_cnt", int'(frame_cnt),   0);
    check("reset err_cnt",   int'(err_cnt),     0);

    // Release mid-line; nothing may be written before the next frame start.
    rst_n = 1'b1;
    snap();
    cyc(1'b0, 1'b1, 1'b0, 24'h11);
    idle(2);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) cyc(1'b0, 1'b1, 1'b0, 24'(p + 32));
      idle(2);
    end
    check("midframe writes",   tot_wr - s_wr,     0);
    check("midframe lalign",   tot_lal - s_lal,   0);
    check("midframe line_err", tot_lerr - s_lerr, 0);
    vs_pulse();
    check("first falign",      tot_fal - s_fal,   1);
    check("first frame_err",   tot_ferr - s_ferr, 0);

    // Table of whole frames, each closed by the next frame start.
    for (int r = 0; r < NV; r++) begin
      hact_s = 16'(vecs[r].hact);
      vact_s = 16'(vecs[r].vact);
      snap();
      g = 0;
      for (int l = 0; l < vecs[r].nlines; l++)
        line((l == vecs[r].odd_line) ? vecs[r].odd_len : vecs[r].len,
             l, vecs[r].vact, vecs[r].full_at, 1'b0);
      check($sformatf("r%0d overflow", r), int'(overflow), vecs[r].e_ovf);
      vs_pulse();
      check($sformatf("r%0d writes", r),    tot_wr - s_wr,     vecs[r].e_wr);
      check($sformatf("r%0d lalign", r),    tot_lal - s_lal,   vecs[r].e_lal);
      check($sformatf("r%0d ealign", r),    tot_eal - s_eal,   vecs[r].e_eal);
      check($sformatf("r%0d line_err", r),  tot_lerr - s_lerr, vecs[r].e_lerr);
      check($sformatf("r%0d frame_err", r), tot_ferr - s_ferr, vecs[r].e_ferr);
      check($sformatf("r%0d falign", r),    tot_fal - s_fal,   1);
      check($sformatf("r%0d ovf cleared", r), int'(overflow),  0);
      check($sformatf("r%0d data", r),      int'(xor_data),    int'(exp_xor));
    end

    // Last line's de fall coincides with the frame start.
    hact_s = 16'd4;
    vact_s = 16'd3;
    snap();
    g = 0;
    line(4, 0, 3, 0, 1'b0);
    line(4, 1, 3, 0, 1'b0);
    line(4, 2, 3, 0, 1'b1);
    idle(3);
    check("coinc writes",    tot_wr - s_wr,     12);
    check("coinc lalign",    tot_lal - s_lal,   3);
    check("coinc ealign",    tot_eal - s_eal,   1);
    check("coinc line_err",  tot_lerr - s_lerr, 0);
    check("coinc frame_err", tot_ferr - s_ferr, 0);
    check("coinc falign",    tot_fal - s_fal,   1);
    // Line count must restart from zero for the following frame.
    snap();
    g = 0;
    for (int l = 0; l < 3; l++) line(4, l, 3, 0, 1'b0);
    vs_pulse();
    check("post-coinc ealign",    tot_eal - s_eal,   1);
    check("post-coinc frame_err", tot_ferr - s_ferr, 0);
    check("post-coinc data",      int'(xor_data),    int'(exp_xor));

    // Statistics over three frames, one with a long line.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    vs_pulse();
    g = 0;
    for (int l = 0; l < 3; l++) line(4, l, 3, 0, 1'b0);
    vs_pulse();
    g = 0;
    for (int l = 0; l < 3; l++) line((l == 1) ? 5 : 4, l, 3, 0, 1'b0);
    vs_pulse();
    g = 0;
    for (int l = 0; l < 3; l++) line(4, l, 3, 0, 1'b0);
    idle(2);
`ifdef NATIVE_IN_STATS_EN
    check("stats frame_cnt", int'(frame_cnt), 3);
    check("stats err_cnt",   int'(err_cnt),   1);
`else
    check("stats frame_cnt off", int'(frame_cnt), 0);
    check("stats err_cnt off",   int'(err_cnt),   0);
`endif
    check("final data", int'(xor_data), int'(exp_xor));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
